// File: rtl/sa_sig_packer.sv
// Systolic-array control-word writer: collects per-row (f_sel, ncols) entries, packs one word per
// N_ROWS_ARRAY rows and writes the words to the signal memory at consecutive addresses.
module sa_sig_packer #(
    parameter int unsigned N_ROWS_ARRAY    = 4,
    parameter int unsigned N               = 3,
    parameter int unsigned SEL_WIDTH       = $clog2(N),
    parameter int unsigned NUM_COL_WIDTH   = $clog2(N + 1),
    parameter int unsigned ROM_SIG_WIDTH   = 100,
    parameter int unsigned SIG_ADDRS_WIDTH = 10
) (
    input  logic                       clk_i,
    input  logic                       general_rst_n_i,
    input  logic                       start_i,
    input  logic [SIG_ADDRS_WIDTH-1:0] base_addrs_i,
    input  logic [SIG_ADDRS_WIDTH:0]   num_words_i,
    input  logic                       entry_valid_i,
    output logic                       entry_ready_o,
    input  logic [SEL_WIDTH-1:0]       entry_f_sel_i,
    input  logic [NUM_COL_WIDTH-1:0]   entry_ncols_i,
    output logic                       wr_en_o,
    output logic [SIG_ADDRS_WIDTH-1:0] wr_addrs_o,
    output logic [ROM_SIG_WIDTH-1:0]   wr_data_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o
);

    localparam int unsigned FieldW = N_ROWS_ARRAY * (SEL_WIDTH + NUM_COL_WIDTH);
    localparam int unsigned RowW   = (N_ROWS_ARRAY > 1) ? $clog2(N_ROWS_ARRAY) : 1;
    localparam int unsigned CntW   = SIG_ADDRS_WIDTH + 1;

    if (FieldW > ROM_SIG_WIDTH) begin : g_width_check
        $fatal(1, "sa_sig_packer: packed fields do not fit in ROM_SIG_WIDTH");
    end

    typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_e;

    state_e                                        state_q, state_d;
    logic [RowW-1:0]                               row_cnt_q, row_cnt_d;
    logic [CntW-1:0]                               word_cnt_q, word_cnt_d;
    logic [CntW-1:0]                               num_words_q, num_words_d;
    logic [SIG_ADDRS_WIDTH-1:0]                    base_q, base_d;
    logic [N_ROWS_ARRAY-1:0][SEL_WIDTH-1:0]        fsel_q, fsel_d;
    logic [N_ROWS_ARRAY-1:0][NUM_COL_WIDTH-1:0]    ncols_q, ncols_d;
    logic                                          err_q, err_d;
    logic [SIG_ADDRS_WIDTH-1:0]                    addr_q, addr_d;
    logic [ROM_SIG_WIDTH-1:0]                      data_q, data_d;

    always_ff @(posedge clk_i or negedge general_rst_n_i) begin
        if (!general_rst_n_i) begin
            state_q     <= StIdle;
            row_cnt_q   <= '0;
            word_cnt_q  <= '0;
            num_words_q <= '0;
            base_q      <= '0;
            fsel_q      <= '0;
            ncols_q     <= '0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            word_cnt_q  <= word_cnt_d;
            num_words_q <= num_words_d;
            base_q      <= base_d;
            fsel_q      <= fsel_d;
            ncols_q     <= ncols_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        row_cnt_d     = row_cnt_q;
        word_cnt_d    = word_cnt_q;
        num_words_d   = num_words_q;
        base_d        = base_q;
        fsel_d        = fsel_q;
        ncols_d       = ncols_q;
        err_d         = err_q;
        addr_d        = addr_q;
        data_d        = data_q;
        entry_ready_o = 1'b0;
        wr_en_o       = 1'b0;
        done_o        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    base_d      = base_addrs_i;
                    num_words_d = num_words_i;
                    err_d       = 1'b0;
                    row_cnt_d   = '0;
                    word_cnt_d  = '0;
                    fsel_d      = '0;
                    ncols_d     = '0;
                    state_d     = (num_words_i == '0) ? StDone : StCollect;
                end
            end
            StCollect: begin
                entry_ready_o = 1'b1;
                if (entry_valid_i) begin
                    fsel_d[row_cnt_q]  = entry_f_sel_i;
                    ncols_d[row_cnt_q] = (32'(entry_ncols_i) > N) ? NUM_COL_WIDTH'(N)
                                                                  : entry_ncols_i;
                    if ((32'(entry_f_sel_i) >= N) || (32'(entry_ncols_i) > N)) begin
                        err_d = 1'b1;
                    end
                    row_cnt_d = row_cnt_q + RowW'(1);
                    if (row_cnt_q == RowW'(N_ROWS_ARRAY - 1)) begin
                        // Word registered here so the write cycle can present it while the
                        // shadow is free to clear for the next word.
                        addr_d                = base_q + word_cnt_q[SIG_ADDRS_WIDTH-1:0];
                        data_d                = '0;
                        data_d[FieldW-1:0]    = {ncols_d, fsel_d};
                        state_d               = StWrite;
                    end
                end
            end
            StWrite: begin
                wr_en_o = 1'b1;
                if (word_cnt_q == num_words_q - CntW'(1)) begin
                    state_d = StDone;
                end else begin
                    word_cnt_d = word_cnt_q + CntW'(1);
                    row_cnt_d  = '0;
                    fsel_d     = '0;
                    ncols_d    = '0;
                    state_d    = StCollect;
                end
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy_o     = (state_q != StIdle);
    assign err_o      = err_q;
    assign wr_addrs_o = addr_q;
    assign wr_data_o  = data_q;

endmodule
